// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
// State encoding, master indices and bus widths.
package io_arb_pkg;

  localparam int AW = 6;
  localparam int DW = 8;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/io_arb_rr_arb2.sv
// Two-way winner select: fixed priority to m0 or alternate on ties.
// last = 1 means m1 was granted most recently.
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  logic tie_m0;

  assign tie_m0 = (FIXED_PRIO != 0) || last;

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = tie_m0 ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_arbiter.sv
// Arbitrates two masters onto a shared IO register bus.
// One transaction at a time: ACCESS, optional CAPTURE, DONE.
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic [AW-1:0] m0_a,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m0_di,
  input  logic [DW-1:0] m1_di,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic          m0_re,
  input  logic          m1_re,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          busy,
  output logic [AW-1:0] io_a,
  output logic [DW-1:0] io_di,
  output logic          io_we,
  output logic          io_re,
  input  logic [DW-1:0] io_do
);

  state_t        state;
  state_t        state_d;
  logic [1:0]    gnt_q;
  logic [1:0]    gnt_d;
  logic [1:0]    pick;
  logic          last_q;
  logic          last_d;
  logic [AW-1:0] sel_a;
  logic [DW-1:0] sel_di;
  logic          sel_we;
  logic          sel_re;
  logic          sel_rd;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req ({m1_req, m0_req}),
    .last(last_q),
    .pick(pick)
  );

  assign sel_a  = gnt_q[M1] ? m1_a  : m0_a;
  assign sel_di = gnt_q[M1] ? m1_di : m0_di;
  assign sel_we = gnt_q[M1] ? m1_we : m0_we;
  assign sel_re = gnt_q[M1] ? m1_re : m0_re;
  // write wins when both qualifiers are set
  assign sel_rd = sel_re & ~sel_we;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      gnt_q    <= 2'b00;
      last_q   <= 1'b1;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      if (state == CAPTURE && gnt_q[M0])
        m0_rdata <= io_do;
      if (state == CAPTURE && gnt_q[M1])
        m1_rdata <= io_do;
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    last_d  = last_q;
    io_a    = '0;
    io_di   = '0;
    io_we   = 1'b0;
    io_re   = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pick) begin
          gnt_d   = pick;
          last_d  = pick[M1];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        io_a    = sel_a;
        io_di   = sel_di;
        io_we   = sel_we;
        io_re   = sel_rd;
        state_d = sel_rd ? CAPTURE : DONE;
      end
      CAPTURE: begin
        state_d = DONE;
      end
      DONE: begin
        m0_ack  = gnt_q[M0];
        m1_ack  = gnt_q[M1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state != IDLE);
  assign m0_gnt = gnt_q[M0] & busy;
  assign m1_gnt = gnt_q[M1] & busy;

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: vector table, directed corner cases,
// and random traffic against a transaction-level model.
module tb_io_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       m0_req, m1_req;
  logic [5:0] m0_a, m1_a;
  logic [7:0] m0_di, m1_di;
  logic       m0_we, m1_we, m0_re, m1_re;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic       m0_gnt, m1_gnt, busy;
  logic [5:0] io_a;
  logic [7:0] io_di;
  logic       io_we, io_re;
  logic [7:0] io_do;

  logic       f_m0_ack, f_m1_ack;
  logic [7:0] f_m0_rdata, f_m1_rdata;
  logic       f_m0_gnt, f_m1_gnt, f_busy;
  logic [5:0] f_io_a;
  logic [7:0] f_io_di;
  logic       f_io_we, f_io_re;
  wire  [7:0] f_io_do = 8'h00;

  io_arbiter #(.FIXED_PRIO(0)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_a(m0_a), .m1_a(m1_a),
    .m0_di(m0_di), .m1_di(m1_di),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_re(m0_re), .m1_re(m1_re),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .busy(busy),
    .io_a(io_a), .io_di(io_di),
    .io_we(io_we), .io_re(io_re), .io_do(io_do)
  );

  io_arbiter #(.FIXED_PRIO(1)) u_fix (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_a(m0_a), .m1_a(m1_a),
    .m0_di(m0_di), .m1_di(m1_di),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_re(m0_re), .m1_re(m1_re),
    .m0_ack(f_m0_ack), .m1_ack(f_m1_ack),
    .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
    .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt), .busy(f_busy),
    .io_a(f_io_a), .io_di(f_io_di),
    .io_we(f_io_we), .io_re(f_io_re), .io_do(f_io_do)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'hA5 + 8'(i);
  endfunction

  // peripheral: registers io_do one cycle after io_re
  logic [7:0] pmem [64];
  logic       reload = 1'b1;
  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 64; i++) pmem[i] <= init_val(i);
    end else if (io_we) begin
      pmem[io_a] <= io_di;
    end
    io_do <= io_re ? pmem[io_a] : 8'h00;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic r, input logic [5:0] a,
                       input logic [7:0] di, input logic we,
                       input logic re);
    if (m == 0) begin
      m0_req = r; m0_a = a; m0_di = di; m0_we = we; m0_re = re;
    end else begin
      m1_req = r; m1_a = a; m1_di = di; m1_we = we; m1_re = re;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reload = 1'b1;
    set_m(0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
    set_m(1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reload = 1'b0;
  endtask

  typedef struct {
    bit         m;
    bit         we;
    bit         re;
    logic [5:0] a;
    logic [7:0] di;
    int         lat;
    int         n_we;
    int         n_re;
    logic [7:0] rd;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int ack_k = -1;
    int nwe = 0;
    int nre = 0;
    int excl = 0;
    logic [5:0] a_s = '0;
    logic [7:0] di_s = '0;
    logic [7:0] rd_s = '0;
    set_m(int'(v.m), 1'b1, v.a, v.di, v.we, v.re);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (io_we) nwe++;
      if (io_re) nre++;
      if (k == 1) begin a_s = io_a; di_s = io_di; end
      if ((m0_ack && m1_ack) || (m0_gnt && m1_gnt)) excl++;
      if (v.m ? m0_ack : m1_ack) excl++;
      if (ack_k < 0 && (v.m ? m1_ack : m0_ack)) begin
        ack_k = k;
        rd_s = v.m ? m1_rdata : m0_rdata;
      end
      step();
      if (ack_k >= 0) begin
        if (v.m) m1_req = 1'b0;
        else m0_req = 1'b0;
      end
    end
    chk({nm, ":lat"}, ack_k, v.lat);
    chk({nm, ":n_we"}, nwe, v.n_we);
    chk({nm, ":n_re"}, nre, v.n_re);
    chk({nm, ":io_a"}, 32'(a_s), 32'(v.a));
    chk({nm, ":io_di"}, 32'(di_s), 32'(v.di));
    chk({nm, ":rdata"}, 32'(rd_s), 32'(v.rd));
    chk({nm, ":excl"}, excl, 0);
  endtask

  function automatic logic [20:0] outs();
    return {m0_ack, m1_ack, m0_gnt, m1_gnt, busy,
            io_we, io_re, io_a, io_di};
  endfunction

  vec_t vt [9];
  logic [7:0] mm [64];

  initial begin
    vec_t v;
    int ak, a0n, a1n, nwe;
    logic [5:0] wa;
    logic [7:0] wdi;
    logic [7:0] dseq, fseq;
    int dn, fn, viol;

    // reset state
    set_m(0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
    set_m(1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset:outs", 32'(outs()), 0);
    chk("reset:rdata", {16'h0, m0_rdata, m1_rdata}, 0);
    chk("reset:fix_busy", 32'(f_busy), 0);
    step();
    rst_n = 1'b1;
    reload = 1'b0;

    // single transactions from idle
    vt[0] = '{1'b0, 1'b1, 1'b0, 6'h01, 8'hFF, 2, 1, 0, 8'h00};
    vt[1] = '{1'b1, 1'b0, 1'b1, 6'h00, 8'h00, 3, 0, 1, 8'hA5};
    vt[2] = '{1'b1, 1'b0, 1'b1, 6'h01, 8'h12, 3, 0, 1, 8'hFF};
    vt[3] = '{1'b0, 1'b1, 1'b1, 6'h02, 8'h3C, 2, 1, 0, 8'h00};
    vt[4] = '{1'b0, 1'b0, 1'b1, 6'h02, 8'h00, 3, 0, 1, 8'h3C};
    vt[5] = '{1'b1, 1'b0, 1'b0, 6'h05, 8'h77, 2, 0, 0, 8'hFF};
    vt[6] = '{1'b0, 1'b0, 1'b1, 6'h3F, 8'h00, 3, 0, 1, 8'hE4};
    vt[7] = '{1'b1, 1'b1, 1'b0, 6'h3F, 8'h11, 2, 1, 0, 8'hFF};
    vt[8] = '{1'b0, 1'b0, 1'b1, 6'h3F, 8'h00, 3, 0, 1, 8'h11};
    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // late req drop still acks; short m1 pulse while busy is ignored
    ak = -1; a0n = 0; a1n = 0; nwe = 0; wa = '0; wdi = '0;
    set_m(0, 1'b1, 6'h07, 8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) set_m(1, 1'b1, 6'h08, 8'h99, 1'b1, 1'b0);
      if (k == 2) begin
        set_m(0, 1'b0, 6'h3E, 8'h00, 1'b0, 1'b1);
        m1_req = 1'b0;
      end
      @(negedge clk);
      if (m0_ack) begin a0n++; ak = k; end
      if (m1_ack) a1n++;
      if (io_we) begin nwe++; wa = io_a; wdi = io_di; end
      step();
    end
    chk("drop:m0_ack_cyc", ak, 2);
    chk("drop:m0_ack_cnt", a0n, 1);
    chk("drop:m1_ack_cnt", a1n, 0);
    chk("drop:n_we", nwe, 1);
    chk("drop:io_a", 32'(wa), 32'h07);
    chk("drop:io_di", 32'(wdi), 32'h5A);
    v = '{1'b1, 1'b0, 1'b1, 6'h07, 8'h00, 3, 0, 1, 8'h5A};
    run_vec(v, "drop_rb");

    // reset during CAPTURE
    set_m(1, 1'b1, 6'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rstcap:busy_pre", 32'(busy), 1);
    step();
    #2;
    rst_n = 1'b0;
    m1_req = 1'b0;
    #1;
    chk("rstcap:outs", 32'(outs()), 0);
    chk("rstcap:rdata", {16'h0, m0_rdata, m1_rdata}, 0);
    step();
    rst_n = 1'b1;
    v = '{1'b0, 1'b1, 1'b0, 6'h09, 8'h42, 2, 1, 0, 8'h00};
    run_vec(v, "rstcap_after");

    // both requesting continuously: RR vs fixed priority
    do_reset();
    set_m(0, 1'b1, 6'h10, 8'h01, 1'b1, 1'b0);
    set_m(1, 1'b1, 6'h11, 8'h02, 1'b1, 1'b0);
    dseq = '0; fseq = '0; dn = 0; fn = 0; viol = 0;
    for (int k = 0; k < 18; k++) begin
      if (k == 12) m0_req = 1'b0;
      @(negedge clk);
      if (m0_ack || m1_ack) begin dseq = {dseq[6:0], m1_ack}; dn++; end
      if (f_m0_ack || f_m1_ack) begin fseq = {fseq[6:0], f_m1_ack}; fn++; end
      if ((m0_ack && m1_ack) || (m0_gnt && m1_gnt)) viol++;
      if ((f_m0_ack && f_m1_ack) || (f_m0_gnt && f_m1_gnt)) viol++;
      step();
    end
    m1_req = 1'b0;
    chk("both:rr_cnt", dn, 6);
    chk("both:rr_seq", 32'(dseq), 32'h17);
    chk("both:fix_cnt", fn, 6);
    chk("both:fix_seq", 32'(fseq), 32'h03);
    chk("both:excl", viol, 0);

    // random traffic against transaction-level model
    do_reset();
    begin
      int acc_at = -1;
      int ack_at = -1;
      int cur = 0;
      bit last = 1'b1;
      bit pend [2];
      logic cwe, crd;
      logic [5:0] ca;
      logic [7:0] cdi;
      logic [7:0] rde [2];
      logic [1:0] ge, ae;
      logic [20:0] ioe;
      bit bz;
      pend[0] = 1'b0; pend[1] = 1'b0;
      rde[0] = 8'h00; rde[1] = 8'h00;
      cwe = 1'b0; crd = 1'b0; ca = '0; cdi = '0;
      for (int i = 0; i < 64; i++) mm[i] = init_val(i);
      for (int n = 0; n < 800; n++) begin
        for (int m = 0; m < 2; m++) begin
          if (!pend[m]) begin
            if (m == 0) m0_req = 1'b0;
            else m1_req = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
              set_m(m, 1'b1, 6'($urandom_range(0, 63)),
                    8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
              pend[m] = 1'b1;
            end
          end
        end
        @(negedge clk);
        bz = (n >= acc_at) && (n <= ack_at);
        ge = bz ? (cur == 1 ? 2'b10 : 2'b01) : 2'b00;
        ae = (n == ack_at) ? (cur == 1 ? 2'b10 : 2'b01) : 2'b00;
        ioe = (n == acc_at) ? {cwe, crd, ca, cdi} : 21'h0;
        if (n == ack_at && crd) rde[cur] = mm[ca];
        chk("rnd:busy", 32'(busy), 32'(bz));
        chk("rnd:gnt", 32'({m1_gnt, m0_gnt}), 32'(ge));
        chk("rnd:ack", 32'({m1_ack, m0_ack}), 32'(ae));
        chk("rnd:io", 32'({io_we, io_re, io_a, io_di}), 32'(ioe));
        chk("rnd:rdata0", 32'(m0_rdata), 32'(rde[0]));
        chk("rnd:rdata1", 32'(m1_rdata), 32'(rde[1]));
        if (n == ack_at) begin
          pend[cur] = 1'b0;
          if (cwe) mm[ca] = cdi;
        end
        if (n > ack_at && (m0_req || m1_req)) begin
          if (m0_req && m1_req) cur = last ? 0 : 1;
          else cur = m1_req ? 1 : 0;
          last = (cur == 1);
          cwe = cur ? m1_we : m0_we;
          crd = (cur ? m1_re : m0_re) & ~cwe;
          ca  = cur ? m1_a : m0_a;
          cdi = cur ? m1_di : m0_di;
          acc_at = n + 1;
          ack_at = n + (crd ? 3 : 2);
        end
        step();
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin between masters, 1 = master 0 always wins ties.
REQ-002 SHALL have port sys_clk  in  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req/m1_req  in  1  transaction request, held high until ack.
REQ-005 SHALL have ports m0_a/m1_a  in  6  IO register address; m0_di/m1_di  in  8  write data.
REQ-006 SHALL have ports m0_we/m1_we, m0_re/m1_re  in  1  write / read qualifiers.
REQ-007 SHALL have ports m0_ack/m1_ack  out  1  one-cycle completion pulse; m0_rdata/m1_rdata  out  8  read data.
REQ-008 SHALL have ports m0_gnt/m1_gnt  out  1  master owns bus; busy  out  1  transaction in progress.
REQ-009 SHALL have ports io_a  out  6, io_di  out  8, io_we  out  1, io_re  out  1, io_do  in  8  shared IO peripheral bus (peripherals register io_do one cycle after io_re, drive 0 otherwise).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, CAPTURE, DONE.
REQ-011 IDLE: if any req sampled high, SHALL latch winner into grant register and go ACCESS; else stay IDLE.
REQ-012 Arbitration SHALL be: single requester wins; both requesting -> FIXED_PRIO=1: m0; FIXED_PRIO=0: master not granted last.
REQ-013 last-granted register SHALL update only on grant; reset value = 1 (m0 wins first tie).
REQ-014 ACCESS (exactly one cycle): SHALL drive io_a/io_di from granted master; io_we = master we; io_re = master re & ~we.
REQ-015 Write or null (we=0,re=0) transaction SHALL go ACCESS -> DONE; read SHALL go ACCESS -> CAPTURE -> DONE.
REQ-016 we and re both high SHALL be treated as write only.
REQ-017 CAPTURE: SHALL register io_do into granted master's rdata; other master's rdata unchanged.
REQ-018 DONE: SHALL assert granted master's ack for one cycle, then go IDLE; no new grant in DONE.
REQ-019 Latency from req sampled in IDLE: write ack 2 cycles later, read ack 3 cycles later; min request spacing 3 (write) / 4 (read) cycles.
REQ-020 Outside ACCESS, io_we = io_re = 0 and io_a/io_di = 0.
REQ-021 mN_gnt SHALL be high from ACCESS through DONE for the granted master only; busy = (state != IDLE).
REQ-022 Master address/data/qualifiers SHALL be sampled during ACCESS only; changes after ACCESS have no effect.
REQ-023 req dropped before grant: no transaction, no ack; req dropped after grant: transaction completes, ack still pulsed.
REQ-024 rdata SHALL hold last captured value until the next read by that master.
REQ-025 Never more than one ack or gnt high in any cycle.

Reset
REQ-026 sys_rst_n low SHALL immediately force: state IDLE, grant none, last-granted = 1, all acks/gnts/busy 0, io_we/io_re/io_a/io_di 0, both rdata 8'h00.
REQ-027 Reset mid-transaction SHALL abort it without ack; first cycle after release behaves as IDLE.

Structure
REQ-028 Package io_arb_pkg SHALL hold the state encoding (2-bit), master index constants, IO address width 6 and data width 8.
REQ-029 Winner selection SHALL be sub-module rr_arb2 (2 reqs, last-granted, FIXED_PRIO -> one-hot pick), purely combinational.

Verification
REQ-030 m0 write a=6'h01, di=8'hFF -> io_we=1, io_a=6'h01, io_di=8'hFF for exactly one cycle; m0_ack 2 cycles after req sampled.
REQ-031 m1 read a=6'h00 with peripheral returning 8'hA5 -> io_re one cycle, m1_rdata=8'hA5 when m1_ack pulses 3 cycles after req.
REQ-032 Both req continuously, FIXED_PRIO=0 -> grants alternate m0, m1, m0, m1; FIXED_PRIO=1 -> m0 only until m0_req drops.
REQ-033 m0 req high during ACCESS then dropped -> ack still pulses; m1 req pulsed one cycle while m0 granted and dropped -> no m1 transaction.
REQ-034 sys_rst_n asserted during CAPTURE -> no ack, all outputs 0 same cycle, next req serviced normally after release.
